// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory req/ack handshake with bounded wait,
// upstream stall generation, branch resolution and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC_IN,
    input  logic [31:0] ALU_C_IN,
    input  logic [31:0] RT_DATA_IN,
    input  logic        ZERO_IN,
    input  logic [1:0]  Branch_IN,
    input  logic [4:0]  reg_rd_in,
    input  logic        MEMR_IN,
    input  logic        MEMW_IN,
    input  logic        REGW_IN,
    input  logic        MEM2R_IN,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    input  logic        DM_ACK,
    input  logic [31:0] DM_RDATA,
    output logic        MEM_STALL,
    output logic        PCSRC,
    output logic [31:0] BR_TARGET,
    output logic [31:0] MEMWB_RDATA,
    output logic [31:0] MEMWB_ALU_C,
    output logic [4:0]  MEMWB_RD,
    output logic        MEMWB_REGW,
    output logic        MEMWB_MEM2R,
    output logic        DM_TIMEOUT
);

    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          access;
    logic          is_load;
    logic          abort;
    logic          taken;

    always_comb begin
        access    = MEMR_IN | MEMW_IN;
        is_load   = MEMR_IN & ~MEMW_IN;
        // Ack wins over a timeout that would fire in the same cycle.
        abort     = (state == WAIT) & access & ~DM_ACK & (cnt == CW'(MAX_WAIT));
        // Reset drops the request immediately, before the state has settled.
        DM_REQ    = access & ~abort & ~rst;
        DM_WE     = MEMW_IN & DM_REQ;
        DM_ADDR   = ALU_C_IN;
        DM_WDATA  = RT_DATA_IN;
        MEM_STALL = access & ~DM_ACK & ~abort & ~rst;
        taken     = ((Branch_IN == 2'b01) & ZERO_IN) | ((Branch_IN == 2'b10) & ~ZERO_IN);
        PCSRC     = taken & ~MEM_STALL;
        BR_TARGET = NPC_IN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            MEMWB_RDATA <= '0;
            MEMWB_ALU_C <= '0;
            MEMWB_RD    <= '0;
            MEMWB_REGW  <= 1'b0;
            MEMWB_MEM2R <= 1'b0;
            DM_TIMEOUT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access & ~DM_ACK) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (~access | DM_ACK | abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (abort) begin
                DM_TIMEOUT <= 1'b1;
            end

            // Stalled and aborted cycles both insert a bubble into write-back.
            if (MEM_STALL | abort) begin
                MEMWB_RDATA <= '0;
                MEMWB_ALU_C <= '0;
                MEMWB_RD    <= '0;
                MEMWB_REGW  <= 1'b0;
                MEMWB_MEM2R <= 1'b0;
            end else begin
                MEMWB_RDATA <= (is_load & DM_ACK) ? DM_RDATA : '0;
                MEMWB_ALU_C <= ALU_C_IN;
                MEMWB_RD    <= reg_rd_in;
                MEMWB_REGW  <= REGW_IN;
                MEMWB_MEM2R <= MEM2R_IN;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, placed directly downstream of the EX/MEM pipeline register. It performs the following work:
- Issues load/store requests to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline until each access completes or times out.
- Resolves conditional branches.
- Owns the MEM/WB pipeline register feeding write-back.

## Interface

Parameters:
- MAX_WAIT, 15: maximum number of stalled cycles allowed for one access before abort (≥1).

Reset is asynchronous and active-high. The block has one clock.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- NPC_IN  in  32  branch target computed in EX.
- ALU_C_IN  in  32  ALU result / memory byte address.
- RT_DATA_IN  in  32  store data.
- ZERO_IN  in  1  ALU zero flag.
- Branch_IN  in  2  branch type: 00 none, 01 beq, 10 bne, 11 none.
- reg_rd_in  in  5  destination register.
- MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN  in  1 each  memory-read, memory-write, reg-write and mem-to-reg controls.
- DM_REQ  out  1  data-memory request.
- DM_WE  out  1  write enable; valid while DM_REQ is high.
- DM_ADDR  out  32  equals ALU_C_IN, unmodified.
- DM_WDATA  out  32  equals RT_DATA_IN.
- DM_ACK  in  1  access complete this cycle.
- DM_RDATA  in  32  load data; valid with DM_ACK.
- MEM_STALL  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (drives EX_MEM_WR low).
- PCSRC  out  1  branch taken.
- BR_TARGET  out  32  equals NPC_IN.
- MEMWB_RDATA, MEMWB_ALU_C  out  32 each  registered load data and ALU result.
- MEMWB_RD  out  5  registered destination.
- MEMWB_REGW, MEMWB_MEM2R  out  1 each  registered write-back controls.
- DM_TIMEOUT  out  1  sticky; an access was aborted.

## Operation

- An access is requested when MEMR_IN or MEMW_IN is high. If both are high, the access is a write (DM_WE=1) and the read is ignored.
- FSM states:
  - IDLE: if an access is requested, assert DM_REQ. If DM_ACK is also high, the access completes this cycle with no stall and the FSM stays in IDLE. Otherwise MEM_STALL is asserted and the FSM goes to WAIT with cnt=1.
  - WAIT: hold DM_REQ; EX/MEM inputs are frozen and therefore stable.
    - On DM_ACK: the access completes, MEM_STALL is low this cycle, and the FSM returns to IDLE.
    - If there is no ack and cnt<MAX_WAIT: keep stalling and increment cnt.
    - If there is no ack and cnt==MAX_WAIT: abort. DM_REQ and MEM_STALL are low this cycle; the FSM goes to IDLE and DM_TIMEOUT is set at the edge.
- Combinational outputs:
  - MEM_STALL = access pending & ~DM_ACK & ~abort.
  - PCSRC = ((Branch_IN==01 & ZERO_IN) | (Branch_IN==10 & ~ZERO_IN)) & ~MEM_STALL.
- MEM/WB register update at each edge:
  - Stalled cycle: load a bubble (all MEMWB_* = 0).
  - Completed or no-access cycle: load DM_RDATA (load with ack) or 0 (otherwise), plus ALU_C_IN, reg_rd_in, REGW_IN and MEM2R_IN.
  - Aborted cycle: load a bubble. The aborted load never writes a register.
- DM_TIMEOUT is cleared only by rst.

## Timing

- Reset values:
  - FSM in IDLE, cnt=0.
  - All MEMWB_* = 0, DM_TIMEOUT=0.
  - Combinational outputs follow from IDLE state with the current inputs.
- Latency: if the ack arrives k cycles after issue (k=0 means same cycle), MEM_STALL is high for exactly k cycles. MEM/WB receives the result at the edge that ends the ack cycle.
- Worst case: DM_REQ is high for MAX_WAIT cycles, MEM_STALL is high for MAX_WAIT cycles, and abort occurs in cycle MAX_WAIT+1.
- Back-to-back accesses: a new request may issue in the cycle immediately after completion. There are no idle cycles between accesses.
- An ack arriving in the same cycle as abort would otherwise trigger counts as a completion; ack has priority.
- rst asserted mid-access drops DM_REQ immediately and returns all state to reset values. No partial write-back occurs.

## Test plan

- Load to rd=5, addr 0x10, ack in the same cycle with DM_RDATA=0xDEADBEEF -> MEM_STALL never high; next edge gives MEMWB_RDATA=0xDEADBEEF, MEMWB_RD=5, MEMWB_REGW=1.
- Store of 0x1234 to addr 0x20, ack after 3 cycles -> DM_WE=1 and DM_WDATA=0x1234 held for 4 cycles; MEM_STALL high 3 cycles; MEM/WB shows 3 bubbles, then MEMWB_REGW=0.
- MAX_WAIT=4, load with no ack -> DM_REQ high 4 cycles; 5th cycle DM_REQ=0 and MEM_STALL=0; DM_TIMEOUT=1 after that edge; MEM/WB is a bubble.
- beq with ZERO_IN=1 -> PCSRC=1 and BR_TARGET=NPC_IN; bne with ZERO_IN=1 -> PCSRC=0; Branch_IN=11 -> PCSRC=0.
- Two loads back-to-back, each acked after 1 cycle -> stall pattern 1,0,1,0; both results appear in order in MEM/WB.
- rst pulsed in WAIT at cnt=2 -> DM_REQ=0 immediately; after release, FSM in IDLE, DM_TIMEOUT=0, all MEMWB_* = 0.
